// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, addresses instruction memory and holds the F/D latch.
// Priority per edge is reset > redirect > stall > advance; squashes are counted (saturating).
module fetch_stage #(
  parameter logic [31:0] RESET_PC        = 32'd0,
  parameter int          FLUSH_CNT_WIDTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic [31:0]                imem_addr,
  input  logic [31:0]                imem_data,
  input  logic                       stall,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  output logic [31:0]                fd_insn,
  output logic [31:0]                fd_pc,
  output logic [31:0]                fd_pc_plus1,
  output logic                       fd_valid,
  output logic [FLUSH_CNT_WIDTH-1:0] flush_count
);

  logic [31:0] pc;
  logic [31:0] pc_next_seq;

  // 32-bit modulo increment; all-ones wraps to zero silently.
  assign pc_next_seq = pc + 32'd1;
  assign imem_addr   = pc;

  // NOTE: every register here is updated with <= so that all of them sample
  // the pre-edge values of pc and flush_count; blocking writes would race.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc          <= RESET_PC;
      fd_insn     <= 32'd0;
      fd_pc       <= 32'd0;
      fd_pc_plus1 <= 32'd0;
      fd_valid    <= 1'b0;
      flush_count <= '0;
    end else if (redirect) begin
      // Squash: the latch carries a nop so decode never sees a stale word.
      pc          <= redirect_pc;
      fd_insn     <= 32'd0;
      fd_pc       <= 32'd0;
      fd_pc_plus1 <= 32'd0;
      fd_valid    <= 1'b0;
      if (flush_count != '1)
        flush_count <= flush_count + 1'b1;
    end else if (!stall) begin
      fd_insn     <= imem_data;
      fd_pc       <= pc;
      fd_pc_plus1 <= pc_next_seq;
      fd_valid    <= 1'b1;
      pc          <= pc_next_seq;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand sequences
// for wrap/saturation/reset, then random stimulus against a behavioural model.
module tb_fetch_stage;

  localparam int FCW = 4;

  logic             clock = 1'b0;
  logic             reset, stall, redirect;
  logic [31:0]      redirect_pc, imem_addr, imem_data;
  logic [31:0]      fd_insn, fd_pc, fd_pc_plus1;
  logic             fd_valid;
  logic [FCW-1:0]   flush_count;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_insn, m_fdpc;
  bit          m_valid;
  int          m_flush;

  typedef struct {
    bit          r, s, rd;
    logic [31:0] rpc;
    logic [31:0] e_addr, e_insn, e_fdpc;
    bit          e_valid;
    int          e_flush;
  } vec_t;

  vec_t vt[17];

  fetch_stage #(.RESET_PC(32'd0), .FLUSH_CNT_WIDTH(FCW)) dut (
    .clock       (clock),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fd_insn     (fd_insn),
    .fd_pc       (fd_pc),
    .fd_pc_plus1 (fd_pc_plus1),
    .fd_valid    (fd_valid),
    .flush_count (flush_count)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + a;
  endfunction

  assign imem_data = mem_word(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs at negedge, advance model at posedge, compare #1 later.
  task automatic cycle(input bit r, input bit s, input bit rd, input logic [31:0] rpc);
    @(negedge clock);
    reset = r; stall = s; redirect = rd; redirect_pc = rpc;
    @(posedge clock);
    if (r) begin
      m_pc = 32'd0; m_insn = 32'd0; m_fdpc = 32'd0; m_valid = 0; m_flush = 0;
    end else if (rd) begin
      m_pc = rpc; m_insn = 32'd0; m_fdpc = 32'd0; m_valid = 0;
      m_flush = (m_flush >= (1 << FCW) - 1) ? (1 << FCW) - 1 : m_flush + 1;
    end else if (!s) begin
      m_insn = mem_word(m_pc); m_fdpc = m_pc; m_valid = 1; m_pc = m_pc + 32'd1;
    end
    #1;
    check("model_addr",  imem_addr,   m_pc);
    check("model_insn",  fd_insn,     m_insn);
    check("model_fdpc",  fd_pc,       m_fdpc);
    check("model_plus1", fd_pc_plus1, m_valid ? m_fdpc + 32'd1 : 32'd0);
    check("model_valid", {31'd0, fd_valid},    {31'd0, m_valid});
    check("model_flush", {28'd0, flush_count}, 32'(m_flush));
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;

    //         r  s  rd rpc     addr    insn           fdpc   v  flush
    vt[0]  = '{1, 0, 0, 32'h0,  32'h0,  32'h0,         32'h0, 0, 0};
    vt[1]  = '{1, 0, 0, 32'h0,  32'h0,  32'h0,         32'h0, 0, 0};
    vt[2]  = '{0, 0, 0, 32'h0,  32'h1,  32'h1000_0000, 32'h0, 1, 0};
    vt[3]  = '{0, 0, 0, 32'h0,  32'h2,  32'h1000_0001, 32'h1, 1, 0};
    vt[4]  = '{0, 0, 0, 32'h0,  32'h3,  32'h1000_0002, 32'h2, 1, 0};
    vt[5]  = '{0, 0, 0, 32'h0,  32'h4,  32'h1000_0003, 32'h3, 1, 0};
    vt[6]  = '{0, 0, 0, 32'h0,  32'h5,  32'h1000_0004, 32'h4, 1, 0};
    vt[7]  = '{0, 0, 0, 32'h0,  32'h6,  32'h1000_0005, 32'h5, 1, 0};
    vt[8]  = '{0, 1, 0, 32'h0,  32'h6,  32'h1000_0005, 32'h5, 1, 0};
    vt[9]  = '{0, 1, 0, 32'h0,  32'h6,  32'h1000_0005, 32'h5, 1, 0};
    vt[10] = '{0, 1, 0, 32'h0,  32'h6,  32'h1000_0005, 32'h5, 1, 0};
    vt[11] = '{0, 0, 0, 32'h0,  32'h7,  32'h1000_0006, 32'h6, 1, 0};
    vt[12] = '{0, 0, 0, 32'h0,  32'h8,  32'h1000_0007, 32'h7, 1, 0};
    vt[13] = '{0, 0, 1, 32'h40, 32'h40, 32'h0,         32'h0, 0, 1};
    vt[14] = '{0, 0, 0, 32'h0,  32'h41, 32'h1000_0040, 32'h40, 1, 1};
    vt[15] = '{0, 1, 1, 32'h80, 32'h80, 32'h0,         32'h0, 0, 2};
    vt[16] = '{0, 0, 0, 32'h0,  32'h81, 32'h1000_0080, 32'h80, 1, 2};

    for (int i = 0; i < 17; i++) begin
      cycle(vt[i].r, vt[i].s, vt[i].rd, vt[i].rpc);
      check($sformatf("vec%0d_addr", i),  imem_addr, vt[i].e_addr);
      check($sformatf("vec%0d_insn", i),  fd_insn,   vt[i].e_insn);
      check($sformatf("vec%0d_fdpc", i),  fd_pc,     vt[i].e_fdpc);
      check($sformatf("vec%0d_plus1", i), fd_pc_plus1,
            vt[i].e_valid ? vt[i].e_fdpc + 32'd1 : 32'd0);
      check($sformatf("vec%0d_valid", i), {31'd0, fd_valid}, {31'd0, vt[i].e_valid});
      check($sformatf("vec%0d_flush", i), {28'd0, flush_count}, 32'(vt[i].e_flush));
    end

    // PC wrap at all-ones
    cycle(0, 0, 1, 32'hFFFF_FFFF);
    check("wrap_addr", imem_addr, 32'hFFFF_FFFF);
    cycle(0, 0, 0, 32'h0);
    check("wrap_fdpc",  fd_pc,       32'hFFFF_FFFF);
    check("wrap_plus1", fd_pc_plus1, 32'h0);
    check("wrap_addr0", imem_addr,   32'h0);
    cycle(0, 0, 0, 32'h0);
    check("wrap_fdpc0", fd_pc,       32'h0);
    check("wrap_plus1b", fd_pc_plus1, 32'h1);

    // Counter saturation over 20 back-to-back redirects
    for (int i = 0; i < 20; i++) begin
      cycle(0, 0, 1, 32'(i * 4 + 32'h100));
      check("b2b_valid", {31'd0, fd_valid}, 32'd0);
    end
    check("sat_flush", {28'd0, flush_count}, 32'hF);
    check("sat_addr",  imem_addr, 32'h100 + 19 * 4);

    // Reset in the middle of a redirect/stall sequence
    cycle(1, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 32'h200 + 32'(i));
    check("pre_rst_flush", {28'd0, flush_count}, 32'd3);
    cycle(1, 1, 1, 32'h300);
    check("mid_rst_flush", {28'd0, flush_count}, 32'd0);
    check("mid_rst_addr",  imem_addr, 32'd0);
    check("mid_rst_valid", {31'd0, fd_valid}, 32'd0);

    // Randomised run against the model
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(99) < 3, $urandom_range(99) < 30,
            $urandom_range(99) < 15, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
